// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU datapath blocks, including the
// sequential divider's state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIXUP,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/alu_seq_divider_if.sv
// Start/done handshake and operand/result bundle between the sequencer
// (master) and the sequential divider (slave).
interface alu_seq_divider_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             zero_flag;

  modport master (
    output start, dividend, divisor, is_signed,
    input  busy, done, quotient, remainder, div_by_zero, overflow, zero_flag
  );

  modport slave (
    input  start, dividend, divisor, is_signed,
    output busy, done, quotient, remainder, div_by_zero, overflow, zero_flag
  );

endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from
// the shifted partial remainder, keeping the difference only when non-negative.
module div_sub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The kept remainder is always below the divisor, so WIDTH bits suffice.
  assign trial    = part_rem - {1'b0, divisor_mag};
  assign q_bit    = ~trial[WIDTH];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : part_rem[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider producing one quotient bit per cycle, with
// sign fixup so results match the ALU's signed/unsigned convention.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_divider_if.slave bus
);

  // Reuse the package count width for the default size.
  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] dividend_lat;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             ovf;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;
  logic             overflow_q;
  logic             zero_flag_q;

  logic signed [WIDTH-1:0] dividend_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic                    sign_a;
  logic                    sign_b;
  logic [WIDTH:0]          shifted;
  logic [WIDTH-1:0]        step_rem;
  logic                    step_q;
  logic [WIDTH-1:0]        q_fix;
  logic [WIDTH-1:0]        r_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dividend_s = bus.dividend;
  assign divisor_s  = bus.divisor;
  assign sign_a     = bus.is_signed & dividend_s[WIDTH-1];
  assign sign_b     = bus.is_signed & divisor_s[WIDTH-1];

  assign shifted = {rem, dq[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .part_rem    (shifted),
    .divisor_mag (dmag),
    .next_rem    (step_rem),
    .q_bit       (step_q)
  );

  assign q_fix = neg_if(dq, neg_q);
  assign r_fix = neg_if(rem, neg_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      rem           <= '0;
      dq            <= '0;
      dmag          <= '0;
      dividend_lat  <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz            <= 1'b0;
      ovf           <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      zero_flag_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Load magnitudes; a zero divisor skips straight to fixup.
            dq           <= neg_if(bus.dividend, sign_a);
            dmag         <= neg_if(bus.divisor, sign_b);
            rem          <= '0;
            count        <= CNT_W'(WIDTH - 1);
            dividend_lat <= bus.dividend;
            neg_q        <= sign_a ^ sign_b;
            neg_r        <= sign_a;
            dz           <= (bus.divisor == '0);
            ovf          <= bus.is_signed &&
                            (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (bus.divisor == '1);
            busy_q       <= 1'b1;
            state        <= (bus.divisor == '0) ? FIXUP : ITER;
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          rem   <= step_rem;
          dq    <= {dq[WIDTH-2:0], step_q};
          count <= count - CNT_W'(1);
          if (count == '0) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (dz) begin
            quotient_q  <= '1;
            remainder_q <= dividend_lat;
            zero_flag_q <= 1'b0;
          end else begin
            quotient_q  <= q_fix;
            remainder_q <= r_fix;
            zero_flag_q <= (q_fix == '0);
          end
          div_by_zero_q <= dz;
          overflow_q    <= ovf;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.overflow    = overflow_q;
  assign bus.zero_flag   = zero_flag_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed checks of the 4-bit sequential divider: latency, signed/unsigned
// results, flags, ignored starts, back-to-back starts and mid-operation reset.
module tb_alu_seq_divider;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_divider_if #(.WIDTH(4)) bus ();

  alu_seq_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a divide and walk the expected number of edges until done.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input int n_edges, input string tag);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    for (int i = 1; i <= n_edges; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      if (i < n_edges) begin
        check({tag, " busy"}, {7'd0, bus.busy}, 8'd1);
        check({tag, " done early"}, {7'd0, bus.done}, 8'd0);
      end else begin
        check({tag, " done"}, {7'd0, bus.done}, 8'd1);
        check({tag, " busy at done"}, {7'd0, bus.busy}, 8'd0);
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [3:0] q, input logic [3:0] r,
                           input logic dz, input logic ov, input logic zf);
    check({tag, " q"}, {4'd0, bus.quotient}, {4'd0, q});
    check({tag, " r"}, {4'd0, bus.remainder}, {4'd0, r});
    check({tag, " dz"}, {7'd0, bus.div_by_zero}, {7'd0, dz});
    check({tag, " ovf"}, {7'd0, bus.overflow}, {7'd0, ov});
    check({tag, " zf"}, {7'd0, bus.zero_flag}, {7'd0, zf});
  endtask

  initial begin
    int seen_done;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", {7'd0, bus.busy}, 8'd0);
    check("reset done", {7'd0, bus.done}, 8'd0);
    check_res("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Unsigned 7/2: done after 6 edges
    do_div(4'd7, 4'd2, 1'b0, 6, "u7/2");
    check_res("u7/2", 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    step();
    check("u7/2 done pulse", {7'd0, bus.done}, 8'd0);
    check("u7/2 hold q", {4'd0, bus.quotient}, 8'd3);

    // Signed -7/2
    do_div(4'h9, 4'h2, 1'b1, 6, "s-7/2");
    check_res("s-7/2", 4'hD, 4'hF, 1'b0, 1'b0, 1'b0);
    step();

    // Signed -8/-1 overflow
    do_div(4'h8, 4'hF, 1'b1, 6, "s-8/-1");
    check_res("s-8/-1", 4'h8, 4'h0, 1'b0, 1'b1, 1'b0);
    step();

    // Unsigned 8/15
    do_div(4'h8, 4'hF, 1'b0, 6, "u8/15");
    check_res("u8/15", 4'h0, 4'h8, 1'b0, 1'b0, 1'b1);
    step();

    // Signed 7/-3 -> q=-2, r=1
    do_div(4'h7, 4'hD, 1'b1, 6, "s7/-3");
    check_res("s7/-3", 4'hE, 4'h1, 1'b0, 1'b0, 1'b0);
    step();

    // Divide by zero: done after 2 edges
    do_div(4'd5, 4'd0, 1'b0, 2, "dz5/0");
    check_res("dz5/0", 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
    step();

    // Unsigned 15/4 with an ignored start of 3/1 at edge k+2
    bus.dividend  = 4'd15;
    bus.divisor   = 4'd4;
    bus.is_signed = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.dividend = 4'd3;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("ign busy", {7'd0, bus.busy}, 8'd1);
    step();
    check("ign done", {7'd0, bus.done}, 8'd1);
    check_res("u15/4", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);

    // Back-to-back start in the DONE cycle
    do_div(4'd3, 4'd5, 1'b0, 6, "b2b3/5");
    check_res("b2b3/5", 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    step();

    // Reset at edge k+3 of a divide
    bus.dividend  = 4'd7;
    bus.divisor   = 4'd2;
    bus.is_signed = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst busy", {7'd0, bus.busy}, 8'd0);
    check("rst done", {7'd0, bus.done}, 8'd0);
    check_res("rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done === 1'b1) seen_done++;
    end
    check("rst no done", seen_done[7:0], 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
